// File: rtl/hdbn_encoder.sv
// HDBn / AMI line encoder: NRZ bits are tagged through a ZERO_RUN-deep delay
// line so a B pulse can be retro-fitted ahead of a V, then given polarity on exit.
module hdbn_encoder #(
   parameter int ZERO_RUN = 4,
   parameter int MODE     = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din_valid,
   input  logic       din,
   output logic       dout_valid,
   output logic [1:0] dout,
   output logic       dout_v,
   output logic       dout_b
);

   if (ZERO_RUN < 2 || ZERO_RUN > 8) begin : g_bad_zero_run
      $error("hdbn_encoder: ZERO_RUN must be within 2..8");
   end
   if (MODE < 0 || MODE > 1) begin : g_bad_mode
      $error("hdbn_encoder: MODE must be 0 or 1");
   end

   typedef enum logic [1:0] {
      SYM_ZERO = 2'd0,
      SYM_MARK = 2'd1,
      SYM_B    = 2'd2,
      SYM_V    = 2'd3
   } sym_t;

   localparam logic [3:0] RUN_LEN = ZERO_RUN[3:0];

   sym_t                tag_q [ZERO_RUN];
   logic [ZERO_RUN-1:0] vld_q;
   logic [3:0]          cnt_q, cnt_d;
   logic                par_q, par_d;
   logic                last_neg_q, last_neg_d;
   sym_t                in_tag;
   sym_t                oldest;
   logic                sub_b;
   logic                out_pulse;
   logic                out_neg;

   always_comb begin
      in_tag = din ? SYM_MARK : SYM_ZERO;
      cnt_d  = cnt_q;
      par_d  = par_q;
      sub_b  = 1'b0;
      if (MODE == 0) begin
         if (din) begin
            cnt_d = '0;
            par_d = ~par_q;
         end else if (cnt_q + 4'd1 == RUN_LEN) begin
            in_tag = SYM_V;
            cnt_d  = '0;
            par_d  = 1'b0;
            sub_b  = ~par_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   // V repeats the last polarity; MARK and B alternate it.
   always_comb begin
      oldest     = tag_q[ZERO_RUN-1];
      out_pulse  = (oldest != SYM_ZERO);
      out_neg    = (oldest == SYM_V) ? last_neg_q : ~last_neg_q;
      last_neg_d = out_pulse ? out_neg : last_neg_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ZERO_RUN; i++) begin
            tag_q[i] <= SYM_ZERO;
         end
         vld_q      <= '0;
         cnt_q      <= '0;
         par_q      <= 1'b0;
         last_neg_q <= 1'b1;
         dout_valid <= 1'b0;
         dout       <= 2'b00;
         dout_v     <= 1'b0;
         dout_b     <= 1'b0;
      end else if (din_valid) begin
         tag_q[0] <= in_tag;
         for (int unsigned i = 1; i < ZERO_RUN; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         // The first zero of the run sits one slot short of the exit when V enters.
         if (sub_b) begin
            tag_q[ZERO_RUN-1] <= SYM_B;
         end
         vld_q      <= {vld_q[ZERO_RUN-2:0], 1'b1};
         cnt_q      <= cnt_d;
         par_q      <= par_d;
         last_neg_q <= last_neg_d;
         dout_valid <= vld_q[ZERO_RUN-1];
         dout       <= out_pulse ? (out_neg ? 2'b11 : 2'b01) : 2'b00;
         dout_v     <= (oldest == SYM_V);
         dout_b     <= (oldest == SYM_B);
      end else begin
         dout_valid <= 1'b0;
         dout       <= 2'b00;
         dout_v     <= 1'b0;
         dout_b     <= 1'b0;
      end
   end

endmodule
